calc1_port_driver: RTL and testbench
====================================

// Module: calc1_port_driver
// PURPOSE
//  Upstream requester for one calc1 port. Accepts a whole transaction (cmd, op1, op2) on a valid/ready
//  interface and serialises it onto the two-cycle calc1 request protocol. Waits for the calc1 response,
//  with a timeout, then returns the code and data on a valid/ready response interface.
//  One instance per calc1 port (x4).
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before the driver reports a timeout (>=2)
//  CNT_W           16  width of the optional statistics counters
// PORTS
//  c_clk          in   1      clock
//  reset_n        in   1      asynchronous, active-low reset
//  txn_valid      in   1      transaction offered
//  txn_ready      out  1      driver can accept a transaction
//  txn_cmd        in   [0:3]  calc1 command, forwarded unfiltered
//  txn_op1        in   [0:31] first operand
//  txn_op2        in   [0:31] second operand
//  rsp_valid      out  1      response available
//  rsp_ready      in   1      response consumed
//  rsp_code       out  [0:1]  calc1 response code (0 when rsp_timeout=1)
//  rsp_data       out  [0:31] calc1 result data
//  rsp_timeout    out  1      no calc1 response arrived within TIMEOUT_CYCLES
//  req_cmd_out    out  [0:3]  to calc1 reqN_cmd_in
//  req_data_out   out  [0:31] to calc1 reqN_data_in
//  out_resp       in   [0:1]  from calc1 out_respN
//  out_data       in   [0:31] from calc1 out_dataN
//  stat_txn, stat_err, stat_tmo, stat_spur  out  [CNT_W-1:0]  statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; all outputs are 0; txn_ready rises on the first clock edge after release.
//  FSM: IDLE -> SEND1 -> SEND2 -> WAIT -> HOLD -> IDLE.
//  - IDLE: txn_ready=1. Bus is idle (cmd=0, data=0). On txn_valid&txn_ready the driver latches cmd, op1 and op2.
//    - If the latched cmd is 0: go directly to HOLD with rsp_code=2, rsp_data=0, and no bus activity.
//  - SEND1 (1 cycle): req_cmd_out=cmd, req_data_out=op1.
//  - SEND2 (1 cycle): req_cmd_out=0, req_data_out=op2.
//  - WAIT: bus is idle; timer counts up from 0.
//    - On an edge with out_resp!=0: capture out_resp and out_data, then go to HOLD.
//    - Otherwise, when timer==TIMEOUT_CYCLES-1: go to HOLD with rsp_timeout=1, rsp_code=0, rsp_data=0.
//    - A response arriving on the timeout edge wins (it is captured, not reported as a timeout).
//  - HOLD: rsp_valid=1. rsp_* stay stable until rsp_ready. On the handshake go to IDLE and clear rsp_*.
//    - No new transaction is accepted in the same cycle as the handshake.
//  Latency: accept edge t -> SEND1 drives the bus in cycle t+1 -> WAIT starts at t+3
//    -> rsp_valid the cycle after calc1 responds.
//  A nonzero out_resp in IDLE, SEND1, SEND2 or HOLD is ignored. This includes late responses after a timeout.
//  rsp_data passes the 32-bit value through unchanged; there is no arithmetic in the driver.
// CONFIGURATION
//  CALC1_DRV_STATS_EN defined:
//   - stat_txn counts accepted transactions.
//   - stat_err counts responses with code 2 or 3, including local cmd-0 rejects.
//   - stat_tmo counts timeouts.
//   - stat_spur counts ignored nonzero out_resp cycles.
//   - All counters saturate at all-ones and are cleared by reset_n.
//  Undefined: all stat_* outputs are tied to 0 and no counter flops exist.
// STRUCTURE
//  calc1_pkg holds:
//   - command constants: CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6
//   - response constants: RSP_NONE=0, RSP_OK=1, RSP_ERR=2, RSP_INT=3
//   - the driver state encoding
//  Sub-module calc1_drv_stats holds the four saturating counters. It is instantiated only under
//  CALC1_DRV_STATS_EN. The FSM and timer stay in calc1_port_driver.
// TESTING
//  1. add 0x00000001 + 0x1FFFFFFF -> bus shows cmd=1/op1 then cmd=0/op2; rsp_code=1, rsp_data=0x20000000.
//  2. add 0xFFFFFFFF + 0x00000001 -> rsp_code=2 (overflow); with STATS, stat_err increments by 1.
//  3. txn_cmd=0 -> rsp_valid 1 cycle after accept, rsp_code=2; req_cmd_out stays 0 throughout.
//  4. calc1 stub that never responds -> rsp_timeout=1 exactly 64 cycles into WAIT;
//     a response injected later is ignored (stat_spur+1).
//  5. rsp_ready held low 10 cycles after rsp_valid -> rsp_* stable, txn_ready=0; IDLE follows the handshake.
//  6. reset_n pulsed low mid-WAIT -> all outputs 0 immediately (asynchronously); a clean add 3+4 afterwards gives 7.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared command/response codes and the port-driver state encoding.
// Used by calc1_port_driver and calc1_drv_stats.
package calc1_pkg;

    // calc1 command codes
    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    // calc1 response codes
    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_OK   = 2'd1;
    localparam logic [1:0] RSP_ERR  = 2'd2;
    localparam logic [1:0] RSP_INT  = 2'd3;

    // driver FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } drv_state_t;

    // codes 2 and 3 both count as error responses
    function automatic logic is_err_code(input logic [1:0] code);
        return (code == RSP_ERR) || (code == RSP_INT);
    endfunction

endpackage

// File: rtl/calc1_drv_stats.sv
// calc1_drv_stats: four saturating event counters for one calc1 port driver.
// Counter order in i_inc: [0]=txn, [1]=err, [2]=tmo, [3]=spur.
module calc1_drv_stats #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_inc,
    output logic [CNT_W-1:0] o_txn,
    output logic [CNT_W-1:0] o_err,
    output logic [CNT_W-1:0] o_tmo,
    output logic [CNT_W-1:0] o_spur
);

    logic [3:0][CNT_W-1:0] w_cnt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            // saturating increment, sticks at all-ones
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign o_txn  = w_cnt[0];
    assign o_err  = w_cnt[1];
    assign o_tmo  = w_cnt[2];
    assign o_spur = w_cnt[3];

endmodule

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: serialises one (cmd, op1, op2) transaction onto the
// two-cycle calc1 request bus, waits for the response with a timeout and
// presents it on a valid/ready response interface.
// Optional statistics counters: define CALC1_DRV_STATS_EN.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             c_clk,
    input  logic             reset_n,
    input  logic             txn_valid,
    output logic             txn_ready,
    input  logic [3:0]       txn_cmd,
    input  logic [31:0]      txn_op1,
    input  logic [31:0]      txn_op2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_code,
    output logic [31:0]      rsp_data,
    output logic             rsp_timeout,
    output logic [3:0]       req_cmd_out,
    output logic [31:0]      req_data_out,
    input  logic [1:0]       out_resp,
    input  logic [31:0]      out_data,
    output logic [CNT_W-1:0] stat_txn,
    output logic [CNT_W-1:0] stat_err,
    output logic [CNT_W-1:0] stat_tmo,
    output logic [CNT_W-1:0] stat_spur
);

    localparam int               TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    drv_state_t       r_state;
    drv_state_t       w_state_next;
    logic             r_started;
    logic [3:0]       r_cmd;
    logic [31:0]      r_op1;
    logic [31:0]      r_op2;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_rsp_code;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_timeout;
    logic             w_accept;
    logic             w_got_rsp;
    logic             w_tmo_hit;

    assign w_accept  = txn_valid && txn_ready;
    assign w_got_rsp = (r_state == ST_WAIT) && (out_resp != RSP_NONE);
    assign w_tmo_hit = (r_state == ST_WAIT) && (out_resp == RSP_NONE) && (r_timer == TMR_LAST);

    // state register
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic; a response on the timeout edge takes priority
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = (txn_cmd == CMD_NOP) ? ST_HOLD : ST_SEND1;
            ST_SEND1: w_state_next = ST_SEND2;
            ST_SEND2: w_state_next = ST_WAIT;
            ST_WAIT:  if (w_got_rsp || w_tmo_hit) w_state_next = ST_HOLD;
            ST_HOLD:  if (rsp_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // outputs decoded from state; txn_ready is held low until the first edge after reset
    always_comb begin
        txn_ready    = (r_state == ST_IDLE) && r_started;
        rsp_valid    = (r_state == ST_HOLD);
        req_cmd_out  = CMD_NOP;
        req_data_out = '0;
        case (r_state)
            ST_SEND1: begin
                req_cmd_out  = r_cmd;
                req_data_out = r_op1;
            end
            ST_SEND2: req_data_out = r_op2;
            default:  ;
        endcase
    end

    // transaction latch, WAIT timer and response capture
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started     <= 1'b0;
            r_cmd         <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_timer       <= '0;
            r_rsp_code    <= RSP_NONE;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd <= txn_cmd;
                        r_op1 <= txn_op1;
                        r_op2 <= txn_op2;
                        if (txn_cmd == CMD_NOP) begin
                            r_rsp_code    <= RSP_ERR;
                            r_rsp_data    <= '0;
                            r_rsp_timeout <= 1'b0;
                        end
                    end
                end
                ST_SEND2: r_timer <= '0;
                ST_WAIT: begin
                    if (w_got_rsp) begin
                        r_rsp_code    <= out_resp;
                        r_rsp_data    <= out_data;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_rsp_code    <= RSP_NONE;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_code    <= RSP_NONE;
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_code    = r_rsp_code;
    assign rsp_data    = r_rsp_data;
    assign rsp_timeout = r_rsp_timeout;

`ifdef CALC1_DRV_STATS_EN
    logic [3:0] w_inc;
    assign w_inc[0] = w_accept;
    assign w_inc[1] = (w_accept && (txn_cmd == CMD_NOP)) || (w_got_rsp && is_err_code(out_resp));
    assign w_inc[2] = w_tmo_hit;
    assign w_inc[3] = (out_resp != RSP_NONE) && (r_state != ST_WAIT);

    calc1_drv_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .i_clk   (c_clk),
        .i_rst_n (reset_n),
        .i_inc   (w_inc),
        .o_txn   (stat_txn),
        .o_err   (stat_err),
        .o_tmo   (stat_tmo),
        .o_spur  (stat_spur)
    );
`else
    assign stat_txn  = '0;
    assign stat_err  = '0;
    assign stat_tmo  = '0;
    assign stat_spur = '0;
`endif

endmodule

// File: tb/tb_calc1_port_driver.sv
// tb_calc1_port_driver: directed test of calc1_port_driver with a hand-driven
// calc1 response side. Stats checks follow CALC1_DRV_STATS_EN.
module tb_calc1_port_driver;

    localparam int CNT_W = 16;

    logic             c_clk = 1'b0;
    logic             reset_n;
    logic             txn_valid;
    logic             txn_ready;
    logic [3:0]       txn_cmd;
    logic [31:0]      txn_op1;
    logic [31:0]      txn_op2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_code;
    logic [31:0]      rsp_data;
    logic             rsp_timeout;
    logic [3:0]       req_cmd_out;
    logic [31:0]      req_data_out;
    logic [1:0]       out_resp;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] stat_txn;
    logic [CNT_W-1:0] stat_err;
    logic [CNT_W-1:0] stat_tmo;
    logic [CNT_W-1:0] stat_spur;

    int total_cnt = 0;
    int bad_cnt   = 0;

    calc1_port_driver #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (CNT_W)
    ) dut (
        .c_clk        (c_clk),
        .reset_n      (reset_n),
        .txn_valid    (txn_valid),
        .txn_ready    (txn_ready),
        .txn_cmd      (txn_cmd),
        .txn_op1      (txn_op1),
        .txn_op2      (txn_op2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_code     (rsp_code),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .req_cmd_out  (req_cmd_out),
        .req_data_out (req_data_out),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .stat_txn     (stat_txn),
        .stat_err     (stat_err),
        .stat_tmo     (stat_tmo),
        .stat_spur    (stat_spur)
    );

    always #5 c_clk = ~c_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // offer one transaction; returns sampled in SEND1 (or HOLD for cmd 0)
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!txn_ready && n < 20) begin
            step();
            n++;
        end
        check_val("send_ready", txn_ready, 1);
        txn_valid = 1'b1;
        txn_cmd   = c;
        txn_op1   = a;
        txn_op2   = b;
        step();
        txn_valid = 1'b0;
        txn_cmd   = '0;
        txn_op1   = '0;
        txn_op2   = '0;
    endtask

    // calc1 answers for one cycle
    task automatic respond(input logic [1:0] code, input logic [31:0] data);
        out_resp = code;
        out_data = data;
        step();
        out_resp = '0;
        out_data = '0;
    endtask

    // check held response, then handshake and check return to idle
    task automatic finish_rsp(input logic [1:0] code, input logic [31:0] data, input logic tmo);
        check_val("rsp_valid", rsp_valid, 1);
        check_val("rsp_code", rsp_code, code);
        check_val("rsp_data", rsp_data, data);
        check_val("rsp_timeout", rsp_timeout, tmo);
        check_val("hold_txn_ready", txn_ready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("idle_rsp_valid", rsp_valid, 0);
        check_val("idle_rsp_code", rsp_code, 0);
        check_val("idle_txn_ready", txn_ready, 1);
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        txn_valid = 1'b0;
        txn_cmd   = '0;
        txn_op1   = '0;
        txn_op2   = '0;
        rsp_ready = 1'b0;
        out_resp  = '0;
        out_data  = '0;

        // reset state
        repeat (2) step();
        check_val("rst_txn_ready", txn_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_bus", {req_cmd_out, req_data_out}, 0);
        @(negedge c_clk);
        reset_n = 1'b1;
        #1;
        check_val("rel_txn_ready", txn_ready, 0);
        step();
        check_val("first_edge_ready", txn_ready, 1);

        // 1: add 1 + 0x1FFFFFFF
        send(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
        check_val("t1_s1_cmd", req_cmd_out, 1);
        check_val("t1_s1_data", req_data_out, 32'h0000_0001);
        step();
        check_val("t1_s2_cmd", req_cmd_out, 0);
        check_val("t1_s2_data", req_data_out, 32'h1FFF_FFFF);
        step();
        check_val("t1_wait_bus", {req_cmd_out, req_data_out}, 0);
        check_val("t1_wait_valid", rsp_valid, 0);
        step();
        respond(2'd1, 32'h2000_0000);
        finish_rsp(2'd1, 32'h2000_0000, 1'b0);

        // 2: add overflow, calc1 reports error
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        step();
        respond(2'd2, 32'h0000_0000);
        finish_rsp(2'd2, 32'h0000_0000, 1'b0);

        // 3: cmd 0 rejected locally, response one cycle after accept
        send(4'd0, 32'h5, 32'h6);
        check_val("t3_valid_early", rsp_valid, 1);
        check_val("t3_bus_cmd", req_cmd_out, 0);
        finish_rsp(2'd2, 32'h0, 1'b0);
        check_val("t3_bus_after", req_cmd_out, 0);

        // 4: no response -> timeout after 64 WAIT cycles; late response ignored
        send(4'd1, 32'h7, 32'h8);
        step();
        step();
        n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        check_val("t4_tmo_cycles", n, 64);
        respond(2'd1, 32'h1234);
        finish_rsp(2'd0, 32'h0, 1'b1);

        // 4b: response on the timeout edge wins
        send(4'd3, 32'h1, 32'h2);
        step();
        step();
        repeat (63) step();
        respond(2'd3, 32'hDEAD_BEEF);
        finish_rsp(2'd3, 32'hDEAD_BEEF, 1'b0);

        // 5: back-pressure for 10 cycles, then a transaction offered on the handshake cycle
        send(4'd1, 32'h50, 32'h5);
        step();
        step();
        respond(2'd1, 32'h55);
        for (int i = 0; i < 10; i++) begin
            check_val("t5_stable", {rsp_valid, rsp_code, rsp_data, rsp_timeout, txn_ready},
                      {1'b1, 2'd1, 32'h55, 1'b0, 1'b0});
            step();
        end
        txn_valid = 1'b1;
        txn_cmd   = 4'd2;
        txn_op1   = 32'd10;
        txn_op2   = 32'd4;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("t5_hs_valid", rsp_valid, 0);
        check_val("t5_hs_ready", txn_ready, 1);
        check_val("t5_hs_bus", req_cmd_out, 0);
        step();
        txn_valid = 1'b0;
        check_val("t5b_s1_cmd", req_cmd_out, 2);
        check_val("t5b_s1_data", req_data_out, 32'd10);
        step();
        check_val("t5b_s2_data", req_data_out, 32'd4);
        step();
        respond(2'd1, 32'd6);
        finish_rsp(2'd1, 32'd6, 1'b0);

`ifdef CALC1_DRV_STATS_EN
        check_val("stat_txn", stat_txn, 7);
        check_val("stat_err", stat_err, 3);
        check_val("stat_tmo", stat_tmo, 1);
        check_val("stat_spur", stat_spur, 1);
`else
        check_val("stat_tied", {stat_txn, stat_err, stat_tmo, stat_spur}, 0);
`endif

        // 6: asynchronous reset mid-WAIT, then a clean add 3 + 4
        send(4'd1, 32'h1, 32'h1);
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_ctrl", {txn_ready, rsp_valid, rsp_timeout, rsp_code}, 0);
        check_val("t6_rst_bus", {req_cmd_out, req_data_out}, 0);
        check_val("t6_rst_data", rsp_data, 0);
        check_val("t6_rst_stats", {stat_txn, stat_err, stat_tmo, stat_spur}, 0);
        repeat (2) step();
        @(negedge c_clk);
        reset_n = 1'b1;
        #1;
        check_val("t6_rel_ready", txn_ready, 0);
        step();
        check_val("t6_first_ready", txn_ready, 1);
        send(4'd1, 32'd3, 32'd4);
        step();
        step();
        respond(2'd1, 32'd7);
        finish_rsp(2'd1, 32'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
